// File: rtl/vga_timing_gen.sv
// VGA pixel-coordinate and sync generator: one pixel per vga_clk, 640x480@60 by default.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by one clock to line up with registered renderer RGB.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HMax       = 10'(H_TOTAL - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VMax       = 10'(V_TOTAL - 1);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Outputs are decoded from the next counter values so they switch on the same edge.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == HMax) begin
      hc_d = '0;
      vc_d = (vc_q == VMax) ? '0 : vc_q + 10'd1;
    end
    blank_d       = (hc_d < HVis) && (vc_d < VVis);
    hs_d          = !((hc_d >= HSyncStart) && (hc_d < HSyncEnd));
    vs_d          = !((vc_d >= VSyncStart) && (vc_d < VSyncEnd));
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc_q          <= HMax;
      vc_q          <= VMax;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q;
  logic vs_dly_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end

  assign hs = hs_dly_q;
  assign vs = vs_dly_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for line timing and reset,
// plus a shrunken instance so whole-frame behaviour fits in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int SyncLag = 1;
`else
  localparam int SyncLag = 0;
`endif

  // Small instance: 32 clocks per line, 13 lines per frame -> 416-clock frame.
  localparam int SmallFrame = 416;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rst_s_n;
  logic [9:0] draw_x, draw_y;
  logic       blank, hs, vs, line_start, frame_start;
  logic [9:0] s_x, s_y;
  logic       s_blank, s_hs, s_vs, s_ls, s_fs;

  int checks = 0;
  int errors = 0;

  vga_timing_gen u_dut (
    .vga_clk    (clk),
    .reset_n    (rst_n),
    .DrawX      (draw_x),
    .DrawY      (draw_y),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(16),
    .H_FP     (4),
    .H_SYNC   (8),
    .H_BP     (4),
    .V_VISIBLE(6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3)
  ) u_small (
    .vga_clk    (clk),
    .reset_n    (rst_s_n),
    .DrawX      (s_x),
    .DrawY      (s_y),
    .blank      (s_blank),
    .hs         (s_hs),
    .vs         (s_vs),
    .line_start (s_ls),
    .frame_start(s_fs)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int blank_lo_x, hs_cnt, hs_first, hs_last, guard;
    int fs_times[$];
    int s_blank_cnt, s_blank_bad, s_vs_cnt, s_vs_x, s_vs_y, s_hs_cnt, s_ls_cnt;
    int s_max_x, s_max_y;

    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) step();
    check_eq("rst_x", draw_x, 799);
    check_eq("rst_y", draw_y, 524);
    check_eq("rst_blank", blank, 0);
    check_eq("rst_hs", hs, 1);
    check_eq("rst_vs", vs, 1);
    check_eq("rst_ls", line_start, 0);
    check_eq("rst_fs", frame_start, 0);

    rst_n = 1'b1;
    step();
    check_eq("first_x", draw_x, 0);
    check_eq("first_y", draw_y, 0);
    check_eq("first_blank", blank, 1);
    check_eq("first_ls", line_start, 1);
    check_eq("first_fs", frame_start, 1);
    check_eq("first_hs", hs, 1);
    step();
    check_eq("second_x", draw_x, 1);
    check_eq("second_ls", line_start, 0);
    check_eq("second_fs", frame_start, 0);

    // Scan the rest of line 0 (DrawX 2..799).
    blank_lo_x = -1;
    hs_cnt     = 0;
    hs_first   = -1;
    hs_last    = -1;
    for (int i = 0; i < 798; i++) begin
      step();
      if (!blank && blank_lo_x < 0) blank_lo_x = int'(draw_x);
      if (!hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(draw_x);
        hs_last = int'(draw_x);
      end
    end
    check_eq("line_end_x", draw_x, 799);
    check_eq("blank_fall_x", blank_lo_x, 640);
    check_eq("hs_low_cnt", hs_cnt, 96);
    check_eq("hs_first_x", hs_first, 656 + SyncLag);
    check_eq("hs_last_x", hs_last, 751 + SyncLag);
    check_eq("line0_vs", vs, 1);
    step();
    check_eq("wrap_x", draw_x, 0);
    check_eq("wrap_y", draw_y, 1);
    check_eq("wrap_ls", line_start, 1);
    check_eq("wrap_fs", frame_start, 0);
    check_eq("wrap_blank", blank, 1);

    // Mid-frame reset.
    guard = 0;
    while (draw_x != 10'd300 && guard < 1000) begin
      step();
      guard++;
    end
    check_eq("seek_x300", draw_x, 300);
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_x", draw_x, 799);
    check_eq("mid_rst_y", draw_y, 524);
    check_eq("mid_rst_blank", blank, 0);
    check_eq("mid_rst_hs", hs, 1);
    rst_n = 1'b1;
    step();
    check_eq("restart_x", draw_x, 0);
    check_eq("restart_y", draw_y, 0);
    check_eq("restart_fs", frame_start, 1);

    // Whole-frame checks on the small instance.
    rst_s_n = 1'b1;
    step();
    check_eq("s_first_x", s_x, 0);
    check_eq("s_first_y", s_y, 0);
    check_eq("s_first_fs", s_fs, 1);
    fs_times.push_back(0);
    s_blank_cnt = 1;
    s_blank_bad = 0;
    s_vs_cnt    = 0;
    s_vs_x      = -1;
    s_vs_y      = -1;
    s_hs_cnt    = 0;
    s_ls_cnt    = 1;
    s_max_x     = 0;
    s_max_y     = 0;
    for (int cyc = 1; cyc <= 2 * SmallFrame; cyc++) begin
      step();
      if (s_fs) fs_times.push_back(cyc);
      if (cyc < SmallFrame) begin
        if (s_blank) s_blank_cnt++;
        if (s_blank && (s_y >= 10'd6 || s_x >= 10'd16)) s_blank_bad++;
        if (!s_vs) begin
          s_vs_cnt++;
          if (s_vs_y < 0) begin
            s_vs_x = int'(s_x);
            s_vs_y = int'(s_y);
          end
        end
        if (!s_hs) s_hs_cnt++;
        if (s_ls) s_ls_cnt++;
        if (int'(s_x) > s_max_x) s_max_x = int'(s_x);
        if (int'(s_y) > s_max_y) s_max_y = int'(s_y);
      end
    end
    check_eq("s_fs_count", fs_times.size(), 3);
    if (fs_times.size() == 3) begin
      check_eq("s_fs_period0", fs_times[1] - fs_times[0], SmallFrame);
      check_eq("s_fs_period1", fs_times[2] - fs_times[1], SmallFrame);
    end
    check_eq("s_blank_cnt", s_blank_cnt, 96);
    check_eq("s_blank_bad", s_blank_bad, 0);
    check_eq("s_vs_cnt", s_vs_cnt, 64);
    check_eq("s_vs_first_y", s_vs_y, 8);
    check_eq("s_vs_first_x", s_vs_x, SyncLag);
    check_eq("s_hs_cnt", s_hs_cnt, 104);
    check_eq("s_ls_cnt", s_ls_cnt, 13);
    check_eq("s_max_x", s_max_x, 31);
    check_eq("s_max_y", s_max_y, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
